// File: rtl/bf16_pkg.sv
// Shared BFloat16 format constants and the packed result type used by the
// normalize/round datapath.
package bf16_pkg;

    localparam int BF16_W  = 16;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 7;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // Positions within the 11-bit normalized mantissa {hidden, frac[6:0], G, R, S}
    localparam int LSB_POS = 3;
    localparam int G_POS   = 2;
    localparam int R_POS   = 1;
    localparam int S_POS   = 0;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } bf16_t;

endpackage

// File: rtl/bf16_round.sv
// Combinational round-to-nearest-even and bf16 pack with overflow/underflow
// classification. Gradual underflow is enabled by BF16_NORM_SUBNORM_EN.
module bf16_round
    import bf16_pkg::*;
#(
    parameter int EW = 11
) (
    input  logic                 sign_i,
    input  logic signed [EW-1:0] exp_i,
    input  logic [10:0]          n_i,
    input  logic                 zero_i,
    output logic [BF16_W-1:0]    res_o,
    output logic                 ovf_o,
    output logic                 unf_o,
    output logic                 zero_o
);

    logic                 rnd_up_s;
    logic [FRAC_W:0]      sum_s;
    logic signed [EW-1:0] exp_r_s;
    logic                 tiny_s;
    bf16_t                res_s;
`ifdef BF16_NORM_SUBNORM_EN
    logic [EW-1:0]        sh_full_s;
    logic [3:0]           shamt_s;
    logic [10:0]          n_sh_s;
    logic [10:0]          n_sub_s;
    logic                 lost_s;
    logic                 rnd_sub_s;
    logic [7:0]           sum_sub_s;
`else
    logic                 unused_s;
    assign unused_s = n_i[10];
`endif

    assign res_o = res_s;

    // Classify, round and pack one result
    always_comb begin
        res_s    = '0;
        ovf_o    = 1'b0;
        unf_o    = 1'b0;
        zero_o   = 1'b0;
        rnd_up_s = n_i[G_POS] & (n_i[R_POS] | n_i[S_POS] | n_i[LSB_POS]);
        // A carry out of the 7-bit fraction leaves it at zero and bumps the exponent
        sum_s    = {1'b0, n_i[9:3]} + {7'd0, rnd_up_s};
        exp_r_s  = sum_s[FRAC_W] ? (exp_i + EW'(1)) : exp_i;
        tiny_s   = exp_i[EW-1] | (exp_i == '0);
`ifdef BF16_NORM_SUBNORM_EN
        sh_full_s = EW'(1) - exp_i;
        shamt_s   = (sh_full_s >= EW'(12)) ? 4'd12 : sh_full_s[3:0];
        n_sh_s    = n_i >> shamt_s;
        lost_s    = ((n_sh_s << shamt_s) != n_i);
        n_sub_s   = {n_sh_s[10:1], n_sh_s[0] | lost_s};
        rnd_sub_s = n_sub_s[G_POS] & (n_sub_s[R_POS] | n_sub_s[S_POS] | n_sub_s[LSB_POS]);
        sum_sub_s = n_sub_s[10:3] + {7'd0, rnd_sub_s};
`endif
        if (zero_i) begin
            res_s.sign = sign_i;
            zero_o     = 1'b1;
        end else if (tiny_s) begin
            res_s.sign = sign_i;
`ifdef BF16_NORM_SUBNORM_EN
            // Rounding into the hidden bit promotes to the smallest normal
            res_s.exp  = {7'd0, sum_sub_s[7]};
            res_s.frac = sum_sub_s[6:0];
            unf_o      = (|n_sub_s[2:0]) | (sum_sub_s == 8'd0);
`else
            unf_o      = 1'b1;
`endif
        end else if (!exp_r_s[EW-1] && (exp_r_s >= EW'(EXP_MAX))) begin
            res_s.sign = sign_i;
            res_s.exp  = 8'hFF;
            ovf_o      = 1'b1;
        end else begin
            res_s.sign = sign_i;
            res_s.exp  = exp_r_s[EXP_W-1:0];
            res_s.frac = sum_s[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/lzc.sv
// Tree leading-zero counter: recursively splits the word in halves.
// W must be a power of two, at least 2; an all-zero input yields W.
module lzc #(
    parameter  int W  = 16,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  x_i,
    output logic [CW-1:0] cnt_o
);

    generate
        if (W == 2) begin : g_leaf
            // Two-bit leaf count
            always_comb begin
                if (x_i[1]) begin
                    cnt_o = 2'd0;
                end else if (x_i[0]) begin
                    cnt_o = 2'd1;
                end else begin
                    cnt_o = 2'd2;
                end
            end
        end else begin : g_node
            localparam int HW = $clog2(W / 2 + 1);
            logic [HW-1:0] cnt_hi_s;
            logic [HW-1:0] cnt_lo_s;

            lzc #(.W(W / 2)) u_hi (.x_i(x_i[W-1:W/2]), .cnt_o(cnt_hi_s));
            lzc #(.W(W / 2)) u_lo (.x_i(x_i[W/2-1:0]), .cnt_o(cnt_lo_s));

            // Upper half all-zero is signalled by its count MSB alone
            always_comb begin
                if (cnt_hi_s[HW-1]) begin
                    cnt_o = {1'b0, cnt_lo_s} + CW'(W / 2);
                end else begin
                    cnt_o = {1'b0, cnt_hi_s};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/bf16_norm.sv
// Two-stage normalize-and-round stage for the bf16 add/sub datapath.
// Optional gradual underflow: define BF16_NORM_SUBNORM_EN.
module bf16_norm
    import bf16_pkg::*;
#(
    parameter int M_W = 12,
    parameter int L_W = 16,
    parameter int E_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              sign_i,
    input  logic [E_W-1:0]    exp_i,
    input  logic [M_W-1:0]    man_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [BF16_W-1:0] res_o,
    output logic              ovf_o,
    output logic              unf_o,
    output logic              zero_o
);

    localparam int C_W = $clog2(L_W + 1);
    // Two spare bits so exp=511 with a carry cannot wrap negative
    localparam int X_W = E_W + 2;

    logic              rdy_en_q;
    logic              accept_s;
    logic              s1_adv_s;
    logic [C_W-1:0]    lzc_cnt_s;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q,  s1_sign_d;
    logic [E_W-1:0]    s1_exp_q,   s1_exp_d;
    logic [M_W-1:0]    s1_man_q,   s1_man_d;
    logic [C_W-1:0]    s1_cnt_q,   s1_cnt_d;

    logic [M_W-2:0]    n_s;
    logic signed [X_W-1:0] e_s;
    logic [BF16_W-1:0] rnd_res_s;
    logic              rnd_ovf_s, rnd_unf_s, rnd_zero_s;

    logic              out_valid_q, out_valid_d;
    logic [BF16_W-1:0] res_q,  res_d;
    logic              ovf_q,  ovf_d;
    logic              unf_q,  unf_d;
    logic              zero_q, zero_d;

    assign s1_adv_s    = s1_valid_q & (~out_valid_q | out_ready_i);
    assign in_ready_o  = rdy_en_q & (~s1_valid_q | s1_adv_s);
    assign accept_s    = in_valid_i & in_ready_o;
    assign out_valid_o = out_valid_q;
    assign res_o       = res_q;
    assign ovf_o       = ovf_q;
    assign unf_o       = unf_q;
    assign zero_o      = zero_q;

    lzc #(.W(L_W)) u_lzc (
        .x_i   ({man_i, {(L_W - M_W){1'b0}}}),
        .cnt_o (lzc_cnt_s)
    );

    // Stage 1 next state: capture on accept, clear once advanced
    always_comb begin
        s1_valid_d = accept_s | (s1_valid_q & ~s1_adv_s);
        if (accept_s) begin
            s1_sign_d = sign_i;
            s1_exp_d  = exp_i;
            s1_man_d  = man_i;
            s1_cnt_d  = lzc_cnt_s;
        end else begin
            s1_sign_d = s1_sign_q;
            s1_exp_d  = s1_exp_q;
            s1_man_d  = s1_man_q;
            s1_cnt_d  = s1_cnt_q;
        end
    end

    // Normalizing shift and exponent adjust for the stage-1 operand
    always_comb begin
        e_s = X_W'(s1_exp_q) + X_W'(1) - X_W'(s1_cnt_q);
        if (s1_cnt_q == '0) begin
            n_s = {s1_man_q[M_W-1:2], s1_man_q[1] | s1_man_q[0]};
        end else begin
            n_s = (M_W - 1)'(s1_man_q << (s1_cnt_q - C_W'(1)));
        end
    end

    bf16_round #(.EW(X_W)) u_round (
        .sign_i (s1_sign_q),
        .exp_i  (e_s),
        .n_i    (n_s),
        .zero_i (s1_man_q == '0),
        .res_o  (rnd_res_s),
        .ovf_o  (rnd_ovf_s),
        .unf_o  (rnd_unf_s),
        .zero_o (rnd_zero_s)
    );

    // Stage 2 next state: results held while the consumer stalls
    always_comb begin
        out_valid_d = s1_adv_s | (out_valid_q & ~out_ready_i);
        if (s1_adv_s) begin
            res_d  = rnd_res_s;
            ovf_d  = rnd_ovf_s;
            unf_d  = rnd_unf_s;
            zero_d = rnd_zero_s;
        end else begin
            res_d  = res_q;
            ovf_d  = ovf_q;
            unf_d  = unf_q;
            zero_d = zero_q;
        end
    end

    // Pipeline registers and the post-reset ready enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_man_q    <= '0;
            s1_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            rdy_en_q    <= 1'b1;
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_man_q    <= s1_man_d;
            s1_cnt_q    <= s1_cnt_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            zero_q      <= zero_d;
        end
    end

endmodule
